// File: rtl/enc_readout_pkg.sv
// Shared types and header layout for the encoder readout sequencer.
// Optional delta readout is controlled by ENC_DELTA_READ_EN (see enc_snapshot_bank).
package enc_readout_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int HDR_NCH_W = 4;

endpackage

// File: rtl/enc_snapshot_bank.sv
// Atomic snapshot of all channel counts, with optional per-channel reference
// registers and delta subtraction when ENC_DELTA_READ_EN is defined.
module enc_snapshot_bank
    import enc_readout_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int COUNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      capture,
    input  logic                      commit,
    input  logic [NUM_CH*COUNT_W-1:0] counts_in,
    output logic [NUM_CH*COUNT_W-1:0] words_out
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [COUNT_W-1:0] snap_q;
            logic [COUNT_W-1:0] snap_d;

            always_comb begin
                snap_d = snap_q;
                if (capture) begin
                    snap_d = counts_in[gi*COUNT_W +: COUNT_W];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    snap_q <= '0;
                end else begin
                    snap_q <= snap_d;
                end
            end

`ifdef ENC_DELTA_READ_EN
            logic [COUNT_W-1:0] ref_q;
            logic [COUNT_W-1:0] ref_d;

            // References only advance on a completed frame, so aborted frames lose no motion.
            always_comb begin
                ref_d = ref_q;
                if (commit) begin
                    ref_d = snap_q;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    ref_q <= '0;
                end else begin
                    ref_q <= ref_d;
                end
            end

            assign words_out[gi*COUNT_W +: COUNT_W] = snap_q - ref_q;
`else
            assign words_out[gi*COUNT_W +: COUNT_W] = snap_q;
`endif
        end
    endgenerate

`ifndef ENC_DELTA_READ_EN
    logic unused_commit;
    assign unused_commit = commit;
`endif

endmodule

// File: rtl/enc_readout_sequencer.sv
// Frame sequencer: snapshots encoder counts on frameStart, then streams a header
// and one word per channel over valid/ready. Delta mode: ENC_DELTA_READ_EN.
module enc_readout_sequencer
    import enc_readout_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int COUNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH*COUNT_W-1:0] encoderCounts,
    input  logic                      frameStart,
    input  logic                      frameEnd,
    output logic [COUNT_W-1:0]        txData,
    output logic                      txValid,
    input  logic                      txReady,
    output logic                      busy,
    output logic [COUNT_W-1:0]        frameSeq
);

    localparam int W_W = $clog2(NUM_CH + 1);

    state_t             state_q, state_d;
    logic [W_W-1:0]     w_q, w_d;
    logic [COUNT_W-1:0] txData_q, txData_d;
    logic [COUNT_W-1:0] frameSeq_q, frameSeq_d;
    logic               capture;
    logic               commit;
    logic [NUM_CH*COUNT_W-1:0] bank_words;
    logic [COUNT_W-1:0] ch_word [NUM_CH];
    logic [COUNT_W-1:0] next_word;
    logic [COUNT_W-1:0] header;

    enc_snapshot_bank #(
        .NUM_CH (NUM_CH),
        .COUNT_W(COUNT_W)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .capture  (capture),
        .commit   (commit),
        .counts_in(encoderCounts),
        .words_out(bank_words)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_word
            assign ch_word[gi] = bank_words[gi*COUNT_W +: COUNT_W];
        end
    endgenerate

    assign header = {frameSeq_q[COUNT_W-1:HDR_NCH_W], HDR_NCH_W'(NUM_CH)};

    // Word w+1 carries channel w, so the current index selects the next channel.
    always_comb begin
        next_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_q == W_W'(k)) begin
                next_word = ch_word[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        txData_d   = txData_q;
        frameSeq_d = frameSeq_q;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (frameStart && !frameEnd) begin
                    state_d  = SEND;
                    w_d      = '0;
                    capture  = 1'b1;
                    txData_d = header;
                end
            end
            SEND: begin
                if (frameEnd) begin
                    state_d  = IDLE;
                    w_d      = '0;
                    txData_d = '0;
                end else if (txReady) begin
                    if (w_q == W_W'(NUM_CH)) begin
                        state_d    = IDLE;
                        w_d        = '0;
                        txData_d   = '0;
                        frameSeq_d = frameSeq_q + 1'b1;
                        commit     = 1'b1;
                    end else begin
                        w_d      = w_q + 1'b1;
                        txData_d = next_word;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            w_q        <= '0;
            txData_q   <= '0;
            frameSeq_q <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            txData_q   <= txData_d;
            frameSeq_q <= frameSeq_d;
        end
    end

    assign txData   = txData_q;
    assign txValid  = (state_q == SEND);
    assign busy     = (state_q == SEND);
    assign frameSeq = frameSeq_q;

endmodule

// File: tb/tb_enc_readout_sequencer.sv
// Randomized bench for enc_readout_sequencer against a frame-level queue model.
module tb_enc_readout_sequencer;

    localparam int NUM_CH  = 4;
    localparam int COUNT_W = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_CH*COUNT_W-1:0] encoderCounts;
    logic                      frameStart;
    logic                      frameEnd;
    logic [COUNT_W-1:0]        txData;
    logic                      txValid;
    logic                      txReady;
    logic                      busy;
    logic [COUNT_W-1:0]        frameSeq;

    logic [COUNT_W-1:0] cnt [NUM_CH];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: the frame is a queue of words still to be sent.
    logic [COUNT_W-1:0] exp_q [$];
    logic [COUNT_W-1:0] acc_q [$];
    logic [COUNT_W-1:0] m_seq;
    logic [COUNT_W-1:0] m_snap [NUM_CH];
    logic [COUNT_W-1:0] m_ref  [NUM_CH];

    always #5 clk = ~clk;

    always_comb begin
        encoderCounts = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            encoderCounts[k*COUNT_W +: COUNT_W] = cnt[k];
        end
    end

    enc_readout_sequencer #(
        .NUM_CH (NUM_CH),
        .COUNT_W(COUNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .encoderCounts(encoderCounts),
        .frameStart   (frameStart),
        .frameEnd     (frameEnd),
        .txData       (txData),
        .txValid      (txValid),
        .txReady      (txReady),
        .busy         (busy),
        .frameSeq     (frameSeq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            exp_q.delete();
            m_seq = '0;
            for (int k = 0; k < NUM_CH; k++) m_ref[k] = '0;
        end else if (exp_q.size() != 0) begin
            if (frameEnd) begin
                exp_q.delete();
            end else if (txReady) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_seq = m_seq + 1'b1;
                    for (int k = 0; k < NUM_CH; k++) m_ref[k] = m_snap[k];
                end
            end
        end else if (frameStart && !frameEnd) begin
            exp_q.push_back({m_seq[COUNT_W-1:4], 4'(NUM_CH)});
            for (int k = 0; k < NUM_CH; k++) begin
                m_snap[k] = cnt[k];
`ifdef ENC_DELTA_READ_EN
                exp_q.push_back(cnt[k] - m_ref[k]);
`else
                exp_q.push_back(cnt[k]);
`endif
            end
        end
    endtask

    // One clock: record accepted words, advance the model, then compare after the edge.
    task automatic cycle();
        if (!reset && txValid && txReady && !frameEnd) acc_q.push_back(txData);
        model_update();
        @(posedge clk);
        #1;
        check("txValid", 32'(txValid), 32'(exp_q.size() != 0));
        check("busy", 32'(busy), 32'(exp_q.size() != 0));
        check("frameSeq", 32'(frameSeq), 32'(m_seq));
        if (exp_q.size() != 0) check("txData", 32'(txData), 32'(exp_q[0]));
        $display("[TB] t=%0t start=%0b end=%0b rdy=%0b valid=%0b data=0x%04h seq=%0d",
                 $time, frameStart, frameEnd, txReady, txValid, txData, frameSeq);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic randomize_counts();
        for (int k = 0; k < NUM_CH; k++) cnt[k] = COUNT_W'($urandom);
    endtask

    // Start a frame and drain it with txReady asserted ready_pct percent of the time.
    task automatic run_frame(input int ready_pct);
        frameStart = 1'b1;
        cycle();
        frameStart = 1'b0;
        for (int i = 0; i < 200; i++) begin
            randomize_counts();
            txReady = ($urandom_range(99) < ready_pct);
            cycle();
            if (!busy) break;
        end
        check("frame_done", 32'(busy), 32'd0);
        txReady = 1'b1;
    endtask

    initial begin
        logic [COUNT_W-1:0] seq_before;
        logic [COUNT_W-1:0] held;
        logic               pat [4];

        reset      = 1'b1;
        frameStart = 1'b0;
        frameEnd   = 1'b0;
        txReady    = 1'b1;
        for (int k = 0; k < NUM_CH; k++) cnt[k] = '0;
        do_reset();
        check("reset_txData", 32'(txData), 32'd0);

        // Basic frame with fixed counts; counts change after the start cycle.
        cnt[0] = 16'h0010; cnt[1] = 16'h0020; cnt[2] = 16'hFFFF; cnt[3] = 16'h0000;
        acc_q.delete();
        run_frame(100);
        check("basic_len", acc_q.size(), 32'd5);
        if (acc_q.size() == 5) begin
            check("basic_w0", 32'(acc_q[0]), 32'h0004);
            check("basic_w1", 32'(acc_q[1]), 32'h0010);
            check("basic_w2", 32'(acc_q[2]), 32'h0020);
            check("basic_w3", 32'(acc_q[3]), 32'hFFFF);
            check("basic_w4", 32'(acc_q[4]), 32'h0000);
        end
        check("basic_seq", 32'(frameSeq), 32'd1);

        // Stall pattern 1,0,0,1: data must hold while stalled.
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        randomize_counts();
        frameStart = 1'b1;
        cycle();
        frameStart = 1'b0;
        for (int i = 0; i < 40 && busy; i++) begin
            txReady = pat[i % 4];
            held = txData;
            cycle();
            if (!pat[i % 4] && busy) check("stall_hold", 32'(txData), 32'(held));
        end
        txReady = 1'b1;

        // Abort after word 2 accepted: no sequence increment.
        seq_before = frameSeq;
        randomize_counts();
        frameStart = 1'b1;
        cycle();
        frameStart = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        frameEnd = 1'b1;
        cycle();
        frameEnd = 1'b0;
        check("abort_valid", 32'(txValid), 32'd0);
        check("abort_seq", 32'(frameSeq), 32'(seq_before));
        frameStart = 1'b1;
        cycle();
        frameStart = 1'b0;
        check("abort_hdr", 32'(txData), 32'({seq_before[COUNT_W-1:4], 4'(NUM_CH)}));
        for (int i = 0; i < 10 && busy; i++) cycle();

        // frameStart+frameEnd together in IDLE: stays idle.
        frameStart = 1'b1;
        frameEnd   = 1'b1;
        cycle();
        frameStart = 1'b0;
        frameEnd   = 1'b0;
        check("startend_busy", 32'(busy), 32'd0);

        // frameStart during SEND: no restart, the model ignores it too.
        frameStart = 1'b1;
        cycle();
        cycle();
        cycle();
        frameStart = 1'b0;
        for (int i = 0; i < 10 && busy; i++) cycle();

        // Delta scenario: 0xFFFE then 0x0003 with an aborted frame between.
        do_reset();
        cnt[0] = 16'hFFFE;
        run_frame(100);
        cnt[0] = 16'h1234;
        frameStart = 1'b1;
        cycle();
        frameStart = 1'b0;
        cycle();
        frameEnd = 1'b1;
        cycle();
        frameEnd = 1'b0;
        cnt[0] = 16'h0003;
        acc_q.delete();
        run_frame(100);
        check("delta_len", acc_q.size(), 32'(NUM_CH + 1));
`ifdef ENC_DELTA_READ_EN
        if (acc_q.size() > 1) check("delta_ch0", 32'(acc_q[1]), 32'h0005);
`else
        if (acc_q.size() > 1) check("raw_ch0", 32'(acc_q[1]), 32'h0003);
`endif

        // Random traffic, including aborts, mid-frame starts and resets.
        for (int i = 0; i < 400; i++) begin
            randomize_counts();
            frameStart = ($urandom_range(99) < 15);
            frameEnd   = ($urandom_range(99) < 4);
            txReady    = ($urandom_range(99) < 70);
            reset      = ($urandom_range(199) == 0);
            cycle();
        end
        reset      = 1'b0;
        frameStart = 1'b0;
        frameEnd   = 1'b0;
        txReady    = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
